core_dmem_arbiter: RTL and testbench
====================================

Name: core_dmem_arbiter

Overview:
- Shares the single data memory port between two requesters:
  - the core LSU, port c_, highest normal priority;
  - a secondary requester, port x_ (debug module / DMA).
- Arbitrates requests and holds the chosen request stable until the memory grants it.
- Routes each response (err/rdata, arriving the cycle after a grant) back to the requester that issued it.
- Starvation of x_ is bounded by a counter that forces priority inversion.

Parameters:
AW, 64, memory address width.
DW, 64, memory data width; strobe width is DW/8.
STARVE_LIMIT, 4, consecutive lost arbitration cycles after which x_ gets priority; range 1..15.

Ports:
g_clk  input  1  global clock; all state on rising edge.
g_resetn  input  1  asynchronous active-low reset.
c_req  input  1  core request; held stable with its payload until c_gnt.
c_addr  input  AW  core address.
c_wen  input  1  core write enable.
c_strb  input  DW/8  core write strobe.
c_wdata  input  DW  core write data.
c_gnt  output  1  core request accepted this cycle.
c_err  output  1  core response error, valid the cycle after c_gnt.
c_rdata  output  DW  core response read data.
x_req, x_addr, x_wen, x_strb, x_wdata  input  same widths as c_ equivalents  secondary request; same hold rule.
x_gnt  output  1  secondary request accepted this cycle.
x_err  output  1  secondary response error.
x_rdata  output  DW  secondary response read data.
m_req  output  1  memory request.
m_addr, m_wen, m_strb, m_wdata  output  as above  muxed request payload.
m_gnt  input  1  memory accepts m_req this cycle.
m_err  input  1  response error, cycle after m_gnt.
m_rdata  input  DW  response data, cycle after m_gnt.
x_starved  output  1  starvation counter at STARVE_LIMIT, i.e. x_ is being forced.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, starve_cnt 0, rsp_vld 0, rsp_own C.
  - All outputs are 0 while reset is asserted: m_req=0, c_gnt=x_gnt=0, c_err=x_err=0.
- FSM states IDLE, LOCK_C, LOCK_X. The selected owner is sel.
- IDLE: sel is chosen combinationally from live requests:
  - x_ if x_req && (x_starved || !c_req);
  - else c_ if c_req;
  - else none.
- LOCK_C / LOCK_X: sel = C / X regardless of the other request.
- m_req = request of sel. m_addr/m_wen/m_strb/m_wdata = payload of sel, or 0 when there is no owner.
- c_gnt = m_gnt && m_req && sel==C. x_gnt likewise for sel==X. The grant path is combinational, zero latency.
- Transitions:
  - any state with m_req && m_gnt -> IDLE;
  - any state with m_req && !m_gnt -> LOCK_<sel>;
  - otherwise -> IDLE.
  - Back-to-back grants every cycle are supported, including alternating owners.
- Locked owner dropping req while locked (protocol violation): m_req follows the owner's req, so it deasserts; FSM -> IDLE next cycle.
- Starvation counter:
  - increments (saturating at STARVE_LIMIT) each cycle x_req && !x_gnt && c_gnt;
  - clears on x_gnt;
  - x_starved = (starve_cnt == STARVE_LIMIT).
- Response tracking:
  - on m_req && m_gnt: rsp_vld<=1, rsp_own<=sel;
  - else rsp_vld<=0.
  - c_err = m_err && rsp_vld && rsp_own==C. x_err = m_err && rsp_vld && rsp_own==X.
  - c_rdata = x_rdata = m_rdata, broadcast; the consumer qualifies it with its own response timing.
- Simultaneous grant and response: the new grant's owner is captured while the previous response is routed by the old rsp_own. No conflict.
- Reset mid-transaction: lock, counter and pending response are discarded. No response is routed after reset release even if m_err is asserted.

Test Plan:
1. Only c_req=1, addr 0x1000, m_gnt=1 -> c_gnt=1 same cycle; m_addr=0x1000; next cycle m_err=1 -> c_err=1, x_err=0.
2. c_req and x_req both 1 from cycle 0, m_gnt=1 always, STARVE_LIMIT=4 -> c_gnt cycles 0-3; x_starved=1 at cycle 4 with x_gnt=1, c_gnt=0; counter 0 at cycle 5.
3. x_req alone, m_gnt=0 for 3 cycles, c_req rises in cycle 1 -> m_addr stays x_addr, FSM LOCK_X; x_gnt on the 4th cycle; c_gnt the following cycle.
4. Alternating grants C,X,C with m_err=1 only on the response to X -> x_err pulses exactly once, one cycle after x_gnt; c_err stays 0.
5. Grant to C, then g_resetn asserted in the response cycle with m_err=1 -> c_err=0, m_req=0; state IDLE and starve_cnt 0 after release.
6. Neither request -> m_req=0, m_addr=0, both gnt=0, rsp_vld stays 0.

Source files
------------

// File: rtl/core_dmem_arbiter.sv
// Shares one data-memory port between the core LSU (c_) and a secondary requester (x_).
// Ports: c_/x_ request+response, m_ memory side, x_starved forcing flag.
module core_dmem_arbiter #(
  parameter int AW           = 64,
  parameter int DW           = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            c_req,
  input  logic [AW-1:0]   c_addr,
  input  logic            c_wen,
  input  logic [DW/8-1:0] c_strb,
  input  logic [DW-1:0]   c_wdata,
  output logic            c_gnt,
  output logic            c_err,
  output logic [DW-1:0]   c_rdata,
  input  logic            x_req,
  input  logic [AW-1:0]   x_addr,
  input  logic            x_wen,
  input  logic [DW/8-1:0] x_strb,
  input  logic [DW-1:0]   x_wdata,
  output logic            x_gnt,
  output logic            x_err,
  output logic [DW-1:0]   x_rdata,
  output logic            m_req,
  output logic [AW-1:0]   m_addr,
  output logic            m_wen,
  output logic [DW/8-1:0] m_strb,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_gnt,
  input  logic            m_err,
  input  logic [DW-1:0]   m_rdata,
  output logic            x_starved
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_C = 2'd1,
    LOCK_X = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_X    = 2'd2
  } own_t;

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rsp_vld_q, rsp_vld_d;
  logic       rsp_own_q, rsp_own_d;
  own_t       sel;
  logic       take;

  assign x_starved = (starve_cnt_q == 4'(STARVE_LIMIT));

  // Owner is forced to none in reset so every request-side output is quiet.
  always_comb begin
    sel = OWN_NONE;
    unique case (state_q)
      LOCK_C:  sel = OWN_C;
      LOCK_X:  sel = OWN_X;
      default: begin
        if (x_req && (x_starved || !c_req)) sel = OWN_X;
        else if (c_req)                     sel = OWN_C;
      end
    endcase
    if (!g_resetn) sel = OWN_NONE;
  end

  always_comb begin
    m_req   = 1'b0;
    m_addr  = '0;
    m_wen   = 1'b0;
    m_strb  = '0;
    m_wdata = '0;
    unique case (1'b1)
      (sel == OWN_C): begin
        m_req   = c_req;
        m_addr  = c_addr;
        m_wen   = c_wen;
        m_strb  = c_strb;
        m_wdata = c_wdata;
      end
      (sel == OWN_X): begin
        m_req   = x_req;
        m_addr  = x_addr;
        m_wen   = x_wen;
        m_strb  = x_strb;
        m_wdata = x_wdata;
      end
      default: ;
    endcase
  end

  assign take  = m_req && m_gnt;
  assign c_gnt = take && (sel == OWN_C);
  assign x_gnt = take && (sel == OWN_X);

  // rsp_own_q: 1 = response belongs to x_.
  assign c_err   = m_err && rsp_vld_q && !rsp_own_q;
  assign x_err   = m_err && rsp_vld_q && rsp_own_q;
  assign c_rdata = m_rdata;
  assign x_rdata = m_rdata;

  always_comb begin
    state_d      = IDLE;
    starve_cnt_d = starve_cnt_q;
    rsp_vld_d    = take;
    rsp_own_d    = rsp_own_q;
    if (m_req && !m_gnt)
      state_d = (sel == OWN_X) ? LOCK_X : LOCK_C;
    if (take)
      rsp_own_d = (sel == OWN_X);
    if (x_gnt)
      starve_cnt_d = '0;
    else if (x_req && c_gnt && !x_starved)
      starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_own_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_own_q    <= rsp_own_d;
    end
  end

endmodule

// File: tb/tb_core_dmem_arbiter.sv
// Testbench for core_dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_core_dmem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req, x_req, c_wen, x_wen, m_gnt, m_err;
  logic [AW-1:0] c_addr, x_addr, m_addr;
  logic [SW-1:0] c_strb, x_strb, m_strb;
  logic [DW-1:0] c_wdata, x_wdata, m_wdata, m_rdata, c_rdata, x_rdata;
  logic          c_gnt, x_gnt, c_err, x_err, m_req, m_wen, x_starved;

  int checks = 0;
  int errors = 0;

  core_dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .g_clk(clk), .g_resetn(rst_n),
    .c_req(c_req), .c_addr(c_addr), .c_wen(c_wen), .c_strb(c_strb),
    .c_wdata(c_wdata), .c_gnt(c_gnt), .c_err(c_err), .c_rdata(c_rdata),
    .x_req(x_req), .x_addr(x_addr), .x_wen(x_wen), .x_strb(x_strb),
    .x_wdata(x_wdata), .x_gnt(x_gnt), .x_err(x_err), .x_rdata(x_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_wen(m_wen), .m_strb(m_strb),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_err(m_err), .m_rdata(m_rdata),
    .x_starved(x_starved)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the port, how long x_ has lost, who owns
  // the response in flight. Owner codes: 0 none, 1 core, 2 secondary.
  int mlock = 0;
  int mstarve = 0;
  bit mpend = 0;
  int mown = 0;

  function automatic int owner();
    if (!rst_n) return 0;
    if (mlock != 0) return mlock;
    if (x_req && (mstarve >= LIM || !c_req)) return 2;
    if (c_req) return 1;
    return 0;
  endfunction

  function automatic bit exp_mreq();
    int o = owner();
    return (o == 1) ? c_req : (o == 2) ? x_req : 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mlock <= 0; mstarve <= 0; mpend <= 0; mown <= 0;
    end else begin
      int o;
      bit g;
      o = owner();
      g = exp_mreq() && m_gnt;
      mlock <= (exp_mreq() && !m_gnt) ? o : 0;
      mpend <= g;
      if (g) mown <= o;
      if (g && o == 2) mstarve <= 0;
      else if (g && o == 1 && x_req) mstarve <= (mstarve < LIM) ? mstarve + 1 : LIM;
    end
  end

  task automatic clear_inputs();
    c_req = 0; c_addr = '0; c_wen = 0; c_strb = '0; c_wdata = '0;
    x_req = 0; x_addr = '0; x_wen = 0; x_strb = '0; x_wdata = '0;
    m_gnt = 0; m_err = 0; m_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 0;
    clear_inputs();
    c_req = 1; c_addr = 64'h55; x_req = 1; m_gnt = 1; m_err = 1;
    @(negedge clk);
    checks++;
    if ({m_req, c_gnt, x_gnt, c_err, x_err, x_starved} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000000",
               {m_req, c_gnt, x_gnt, c_err, x_err, x_starved});
    end
    checks++;
    if (m_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0", m_addr);
    end
    next_cycle();
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_single_c();
    next_cycle();
    c_req = 1; c_addr = 64'h1000; c_wen = 1; c_strb = 8'hF0; m_gnt = 1;
    @(negedge clk);
    checks++;
    if (c_gnt !== 1 || x_gnt !== 0 || m_addr !== 64'h1000 || m_strb !== 8'hF0) begin
      errors++;
      $display("FAIL single_c_gnt got gnt=%b/%b addr=%h strb=%h want 1/0 1000 f0",
               c_gnt, x_gnt, m_addr, m_strb);
    end
    next_cycle();
    clear_inputs();
    m_err = 1; m_rdata = 64'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (c_err !== 1 || x_err !== 0 || c_rdata !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_c_rsp got c_err=%b x_err=%b rdata=%h want 1 0 deadbeef",
               c_err, x_err, c_rdata);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_starve();
    do_reset();
    c_req = 1; c_addr = 64'hC0; x_req = 1; x_addr = 64'hA0; m_gnt = 1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checks++;
      if (cyc < 4) begin
        if (c_gnt !== 1 || x_gnt !== 0 || x_starved !== 0) begin
          errors++;
          $display("FAIL starve_c%0d got c=%b x=%b st=%b want 1 0 0",
                   cyc, c_gnt, x_gnt, x_starved);
        end
      end else if (cyc == 4) begin
        if (c_gnt !== 0 || x_gnt !== 1 || x_starved !== 1 || m_addr !== 64'hA0) begin
          errors++;
          $display("FAIL starve_force got c=%b x=%b st=%b addr=%h want 0 1 1 a0",
                   c_gnt, x_gnt, x_starved, m_addr);
        end
      end else begin
        if (x_starved !== 0 || dut.starve_cnt_q !== 4'd0 || c_gnt !== 1) begin
          errors++;
          $display("FAIL starve_clear got st=%b cnt=%0d c=%b want 0 0 1",
                   x_starved, dut.starve_cnt_q, c_gnt);
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_lock_x();
    do_reset();
    x_req = 1; x_addr = 64'hB00; m_gnt = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc >= 1) begin c_req = 1; c_addr = 64'hC00; end
      if (cyc == 3) m_gnt = 1;
      if (cyc == 4) x_req = 0;
      @(negedge clk);
      checks++;
      if (cyc < 4) begin
        if (m_addr !== 64'hB00 || x_gnt !== (cyc == 3) || c_gnt !== 0) begin
          errors++;
          $display("FAIL lock_x_c%0d got addr=%h x=%b c=%b want b00 %b 0",
                   cyc, m_addr, x_gnt, c_gnt, cyc == 3);
        end
      end else begin
        if (c_gnt !== 1 || x_gnt !== 0 || m_addr !== 64'hC00) begin
          errors++;
          $display("FAIL lock_x_after got c=%b x=%b addr=%h want 1 0 c00",
                   c_gnt, x_gnt, m_addr);
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_alt_err();
    do_reset();
    for (int cyc = 0; cyc < 4; cyc++) begin
      clear_inputs();
      m_gnt = 1;
      c_req = (cyc == 0 || cyc == 2);
      x_req = (cyc == 1);
      m_err = (cyc == 2);
      @(negedge clk);
      checks++;
      if (x_err !== (cyc == 2) || c_err !== 0) begin
        errors++;
        $display("FAIL alt_err_c%0d got x_err=%b c_err=%b want %b 0",
                 cyc, x_err, c_err, cyc == 2);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    c_req = 1; x_req = 1; m_gnt = 1;
    next_cycle();
    next_cycle();
    x_req = 0;
    next_cycle();
    rst_n = 0;
    clear_inputs();
    m_err = 1; c_req = 1;
    @(negedge clk);
    checks++;
    if (c_err !== 0 || x_err !== 0 || m_req !== 0) begin
      errors++;
      $display("FAIL reset_mid got c_err=%b x_err=%b m_req=%b want 0 0 0",
               c_err, x_err, m_req);
    end
    next_cycle();
    rst_n = 1;
    c_req = 0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== 2'd0 || dut.starve_cnt_q !== 4'd0 || c_err !== 0) begin
      errors++;
      $display("FAIL reset_mid_after got st=%0d cnt=%0d c_err=%b want 0 0 0",
               dut.state_q, dut.starve_cnt_q, c_err);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_idle();
    next_cycle();
    clear_inputs();
    m_gnt = 1; m_err = 1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checks++;
      if (m_req !== 0 || m_addr !== '0 || c_gnt !== 0 || x_gnt !== 0 ||
          c_err !== 0 || x_err !== 0) begin
        errors++;
        $display("FAIL idle_c%0d got m_req=%b addr=%h gnt=%b%b err=%b%b want all 0",
                 cyc, m_req, m_addr, c_gnt, x_gnt, c_err, x_err);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    bit c_done = 1, x_done = 1;
    int bad = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (c_done || !c_req) begin
        c_req = ($urandom_range(0, 3) != 0);
        c_addr = {$urandom(), $urandom()}; c_wen = $urandom_range(0, 1);
        c_strb = SW'($urandom()); c_wdata = {$urandom(), $urandom()};
      end
      if (x_done || !x_req) begin
        x_req = ($urandom_range(0, 2) != 0);
        x_addr = {$urandom(), $urandom()}; x_wen = $urandom_range(0, 1);
        x_strb = SW'($urandom()); x_wdata = {$urandom(), $urandom()};
      end
      m_gnt = ($urandom_range(0, 2) != 0);
      m_err = $urandom_range(0, 1);
      m_rdata = {$urandom(), $urandom()};
      @(negedge clk);
      begin
        int o;
        bit er, eg;
        logic [AW-1:0] ea;
        logic [SW-1:0] es;
        logic [DW-1:0] ew;
        bit ewn;
        o = owner();
        er = exp_mreq();
        eg = er && m_gnt;
        ea = (o == 1) ? c_addr : (o == 2) ? x_addr : '0;
        es = (o == 1) ? c_strb : (o == 2) ? x_strb : '0;
        ew = (o == 1) ? c_wdata : (o == 2) ? x_wdata : '0;
        ewn = (o == 1) ? c_wen : (o == 2) ? x_wen : 1'b0;
        checks++;
        if (m_req !== er || c_gnt !== (eg && o == 1) || x_gnt !== (eg && o == 2) ||
            m_addr !== ea || m_strb !== es || m_wdata !== ew || m_wen !== ewn ||
            c_err !== (m_err && mpend && mown == 1) ||
            x_err !== (m_err && mpend && mown == 2) ||
            x_starved !== (mstarve == LIM) || x_rdata !== m_rdata) begin
          errors++;
          if (bad < 10)
            $display("FAIL rand_c%0d got req=%b gnt=%b%b err=%b%b st=%b addr=%h want req=%b own=%0d err_own=%0d/%0d st=%b addr=%h",
                     cyc, m_req, c_gnt, x_gnt, c_err, x_err, x_starved, m_addr,
                     er, o, mpend, mown, mstarve == LIM, ea);
          bad++;
        end
      end
      c_done = c_gnt;
      x_done = x_gnt;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_c();
    test_starve();
    test_lock_x();
    test_alt_err();
    test_reset_mid();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
